// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues credit-limited word fetches,
// buffers in-order responses for decode and flushes stale work on a redirect.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW:0]     CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   ONE          = CW'(1);
    localparam logic [PW-1:0]   LAST_SLOT    = PW'(DEPTH - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);
    localparam logic [XLEN-1:0] START_PC     = RESET_PC & ALIGN_MASK;
    localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);

    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic [XLEN-1:0] resp_pc, resp_pc_next;
    logic [CW-1:0]   outstanding, outstanding_next;
    logic [CW-1:0]   drop, drop_next;
    logic [CW-1:0]   count, count_next;
    logic [PW-1:0]   head, head_next;
    logic [PW-1:0]   tail, tail_next;

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_target;

    function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
        return (ptr == LAST_SLOT) ? '0 : ptr + PW'(1);
    endfunction

    assign redirect_target = redirect_pc & ALIGN_MASK;

    // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
    assign imem_req_valid = !rst && !redirect_valid &&
                            (({1'b0, outstanding} + {1'b0, count}) < CREDIT_LIMIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding can only be a leftover from before reset.
    assign resp_fire = imem_resp_valid && (outstanding != '0);
    assign push      = resp_fire && (drop == '0) && !redirect_valid;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst       = inst_mem[head];
    assign inst_pc    = pc_mem[head];

    always_comb begin
        outstanding_next = outstanding;
        drop_next        = drop;
        count_next       = count;
        head_next        = head;
        tail_next        = tail;
        fetch_pc_next    = fetch_pc;
        resp_pc_next     = resp_pc;

        if (req_fire && !resp_fire) begin
            outstanding_next = outstanding + ONE;
        end else if (!req_fire && resp_fire) begin
            outstanding_next = outstanding - ONE;
        end

        if (redirect_valid) begin
            // Everything still in flight after this cycle's response belongs to the old path.
            drop_next     = outstanding_next;
            count_next    = '0;
            head_next     = '0;
            tail_next     = '0;
            fetch_pc_next = redirect_target;
            resp_pc_next  = redirect_target;
        end else begin
            if (resp_fire && (drop != '0)) begin
                drop_next = drop - ONE;
            end
            if (push) begin
                resp_pc_next = resp_pc + PC_STEP;
                tail_next    = advance(tail);
            end
            if (pop) begin
                head_next = advance(head);
            end
            if (push && !pop) begin
                count_next = count + ONE;
            end else if (!push && pop) begin
                count_next = count - ONE;
            end
            if (req_fire) begin
                fetch_pc_next = fetch_pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= START_PC;
            resp_pc     <= START_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            fetch_pc    <= fetch_pc_next;
            resp_pc     <= resp_pc_next;
            outstanding <= outstanding_next;
            drop        <= drop_next;
            count       <= count_next;
            head        <= head_next;
            tail        <= tail_next;
        end
    end

    // Payload storage needs no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= imem_resp_data;
            pc_mem[tail]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a randomized in-order memory plus a
// PC-stream/credit reference model checks every request and delivered instruction.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    logic        w_rst, w_req_valid, w_req_ready, w_resp_valid;
    logic        w_redirect_valid, w_inst_valid, w_inst_ready;
    logic [31:0] w_req_addr, w_resp_data, w_redirect_pc, w_inst, w_inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .inst(w_inst), .inst_pc(w_inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    req_t        mem_q[$];
    int          epoch    = 0;
    int          buffered = 0;
    int          delivered = 0;
    logic [31:0] next_req_addr, next_exp_pc;
    int          lat_min = 1, lat_max = 1, ready_pct = 100, inst_ready_pct = 100;
    int          first_req, first_valid;
    bit          saw_req, saw_pop;
    logic [31:0] last_req_addr, last_pop_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic void model_reset();
        mem_q.delete();
        buffered      = 0;
        epoch         = epoch + 1;
        next_req_addr = RESET_PC;
        next_exp_pc   = RESET_PC;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later, advance the model.
    task automatic tick(input bit rst_in, input bit redir, input logic [31:0] rpc, input bit stall);
        bit   resp_now, req_fire, pop_fire;
        logic exp_req_valid, exp_inst_valid;
        req_t head;
        rst            = rst_in;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        inst_ready     = stall ? 1'b0 : ($urandom_range(99) < inst_ready_pct);
        resp_now       = !rst_in && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? word_of(mem_q[0].addr) : $urandom;
        #1;
        exp_req_valid  = !rst_in && !redir && ((mem_q.size() + buffered) < DEPTH);
        exp_inst_valid = (buffered != 0);
        checks++;
        if (imem_req_valid !== exp_req_valid) begin
            fails++;
            $display("[TB] FAIL req_valid: got %b expected %b (cycle %0d)", imem_req_valid, exp_req_valid, cyc);
        end
        checks++;
        if (inst_valid !== exp_inst_valid) begin
            fails++;
            $display("[TB] FAIL inst_valid: got %b expected %b (cycle %0d)", inst_valid, exp_inst_valid, cyc);
        end
        req_fire = (imem_req_valid === 1'b1) && imem_req_ready;
        pop_fire = (inst_valid === 1'b1) && inst_ready && !redir && !rst_in;
        if (req_fire) begin
            checks++;
            if (imem_req_addr !== next_req_addr) begin
                fails++;
                $display("[TB] FAIL req_addr: got %h expected %h (cycle %0d)", imem_req_addr, next_req_addr, cyc);
            end
            saw_req       = 1'b1;
            last_req_addr = imem_req_addr;
            if (first_req < 0) first_req = cyc;
        end
        if ((inst_valid === 1'b1) && (first_valid < 0)) first_valid = cyc;
        if (pop_fire) begin
            checks++;
            if (inst_pc !== next_exp_pc) begin
                fails++;
                $display("[TB] FAIL inst_pc: got %h expected %h (cycle %0d)", inst_pc, next_exp_pc, cyc);
            end
            checks++;
            if (inst !== word_of(next_exp_pc)) begin
                fails++;
                $display("[TB] FAIL inst_word: got %h expected %h (cycle %0d)", inst, word_of(next_exp_pc), cyc);
            end
            saw_pop     = 1'b1;
            last_pop_pc = inst_pc;
        end
        if (rst_in) begin
            model_reset();
        end else begin
            if (resp_now) begin
                head = mem_q.pop_front();
                if (!redir && (head.epoch == epoch)) buffered++;
            end
            if (pop_fire) begin
                buffered--;
                delivered++;
                next_exp_pc = next_exp_pc + 32'd4;
            end
            if (req_fire) begin
                mem_q.push_back('{addr: next_req_addr,
                                  due: cyc + int'($urandom_range(lat_max, lat_min)),
                                  epoch: epoch});
                next_req_addr = next_req_addr + 32'd4;
            end
            if (redir) begin
                epoch++;
                buffered      = 0;
                next_req_addr = rpc & 32'hFFFF_FFFC;
                next_exp_pc   = rpc & 32'hFFFF_FFFC;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid);
        end
        checks++;
        if (imem_req_addr !== RESET_PC) begin
            fails++; $display("[TB] FAIL reset_req_addr: got %h expected %h", imem_req_addr, RESET_PC);
        end
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_steady_flow();
        int start;
        lat_min = 1; lat_max = 1; ready_pct = 100; inst_ready_pct = 100;
        first_req = -1; first_valid = -1; start = delivered;
        repeat (24) tick(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if ((first_valid - first_req) != 2) begin
            fails++; $display("[TB] FAIL first_latency: got %0d expected 2", first_valid - first_req);
        end
        checks++;
        if ((delivered - start) < 10) begin
            fails++; $display("[TB] FAIL steady_progress: got %0d expected at least 10", delivered - start);
        end
    endtask

    task automatic test_backpressure();
        int start;
        lat_min = 1; lat_max = 1; ready_pct = 100; inst_ready_pct = 100;
        repeat (5) tick(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL stall_req_valid: got %b expected 0", imem_req_valid);
        end
        checks++;
        if (buffered != DEPTH) begin
            fails++; $display("[TB] FAIL stall_fill: got %0d expected %0d", buffered, DEPTH);
        end
        start = delivered;
        repeat (15) tick(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if ((delivered - start) < 5) begin
            fails++; $display("[TB] FAIL release_progress: got %0d expected at least 5", delivered - start);
        end
    endtask

    task automatic test_redirect();
        int n;
        lat_min = 3; lat_max = 3; ready_pct = 100; inst_ready_pct = 100;
        n = 0;
        while ((mem_q.size() != 2) && (n < 20)) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (mem_q.size() != 2) begin
            fails++; $display("[TB] FAIL redirect_setup: got %0d in flight expected 2", mem_q.size());
        end
        tick(1'b0, 1'b1, 32'h0000_1002, 1'b0);
        checks++;
        if (inst_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL redirect_flush: got %b expected 0", inst_valid);
        end
        saw_req = 1'b0; n = 0;
        while (!saw_req && (n < 30)) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (!saw_req || (last_req_addr !== 32'h0000_1000)) begin
            fails++; $display("[TB] FAIL redirect_req_addr: got %h expected 00001000", last_req_addr);
        end
        saw_pop = 1'b0; n = 0;
        while (!saw_pop && (n < 30)) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (!saw_pop || (last_pop_pc !== 32'h0000_1000)) begin
            fails++; $display("[TB] FAIL redirect_first_pc: got %h expected 00001000", last_pop_pc);
        end
    endtask

    task automatic test_redirect_collide();
        int  n;
        bit  hit;
        lat_min = 1; lat_max = 1; ready_pct = 100; inst_ready_pct = 100;
        n = 0; hit = 1'b0;
        while (!hit && (n < 30)) begin
            if ((inst_valid === 1'b1) && (mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
                hit = 1'b1;
                tick(1'b0, 1'b1, 32'h0000_2000, 1'b0);
            end else begin
                tick(1'b0, 1'b0, '0, 1'b0);
            end
            n++;
        end
        checks++;
        if (!hit) begin
            fails++; $display("[TB] FAIL collide_setup: got no collision expected one within 30 cycles");
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL collide_flush: got %b expected 0", inst_valid);
        end
        saw_pop = 1'b0; n = 0;
        while (!saw_pop && (n < 30)) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (!saw_pop || (last_pop_pc !== 32'h0000_2000)) begin
            fails++; $display("[TB] FAIL collide_first_pc: got %h expected 00002000", last_pop_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs [3];
        logic [31:0] pend_addr;
        logic [31:0] exp_addrs [3];
        bit          pend, fire, got_inst;
        int          n;
        exp_addrs[0] = 32'hFFFF_FFF8; exp_addrs[1] = 32'hFFFF_FFFC; exp_addrs[2] = 32'h0000_0000;
        addrs[0] = '0; addrs[1] = '0; addrs[2] = '0;
        w_rst = 1'b1;
        @(negedge clk);
        w_rst = 1'b0; w_req_ready = 1'b1; w_inst_ready = 1'b1;
        pend = 1'b0; pend_addr = '0; n = 0; got_inst = 1'b0;
        for (int c = 0; (c < 12) && (n < 3); c++) begin
            w_resp_valid = pend;
            w_resp_data  = word_of(pend_addr);
            #1;
            fire = (w_req_valid === 1'b1);
            if (fire) begin
                addrs[n] = w_req_addr;
                n++;
            end
            if ((w_inst_valid === 1'b1) && !got_inst) begin
                got_inst = 1'b1;
                checks++;
                if ((w_inst_pc !== WRAP_PC) || (w_inst !== word_of(WRAP_PC))) begin
                    fails++; $display("[TB] FAIL wrap_first_inst: got %h/%h expected %h/%h",
                                      w_inst_pc, w_inst, WRAP_PC, word_of(WRAP_PC));
                end
            end
            pend = fire;
            pend_addr = w_req_addr;
            @(negedge clk);
        end
        checks++;
        if (n != 3) begin
            fails++; $display("[TB] FAIL wrap_req_count: got %0d expected 3", n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addrs[i] !== exp_addrs[i]) begin
                fails++; $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, addrs[i], exp_addrs[i]);
            end
        end
        w_rst = 1'b1; w_req_ready = 1'b0; w_resp_valid = 1'b0; w_inst_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        lat_min = 4; lat_max = 4; ready_pct = 100; inst_ready_pct = 100;
        n = 0;
        while (!((buffered >= 1) && (mem_q.size() >= 1)) && (n < 30)) begin
            tick(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (!((buffered >= 1) && (mem_q.size() >= 1))) begin
            fails++; $display("[TB] FAIL reset_mid_setup: got %0d buffered %0d in flight", buffered, mem_q.size());
        end
        tick(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (inst_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_mid_inst_valid: got %b expected 0", inst_valid);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_mid_req_valid: got %b expected 0", imem_req_valid);
        end
        checks++;
        if (imem_req_addr !== RESET_PC) begin
            fails++; $display("[TB] FAIL reset_mid_req_addr: got %h expected %h", imem_req_addr, RESET_PC);
        end
        lat_min = 1; lat_max = 2;
        repeat (12) tick(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        int start;
        lat_min = 1; lat_max = 3; ready_pct = 70; inst_ready_pct = 70;
        start = delivered;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                tick(1'b1, 1'b0, '0, 1'b0);
            end else if ($urandom_range(99) < 5) begin
                tick(1'b0, 1'b1, $urandom, 1'b0);
            end else begin
                tick(1'b0, 1'b0, '0, 1'b0);
            end
        end
        checks++;
        if ((delivered - start) < 100) begin
            fails++; $display("[TB] FAIL random_progress: got %0d expected at least 100", delivered - start);
        end
    endtask

    initial begin
        w_rst = 1'b1; w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = '0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0; w_inst_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_steady_flow();
        test_backpressure();
        test_redirect();
        test_redirect_collide();
        test_reset_mid();
        rst = 1'b1;
        test_wrap();
        tick(1'b1, 1'b0, '0, 1'b0);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
